// File: rtl/memory_target_if.sv
// Request/response bundle between the core's memory access unit (master) and a memory target (slave).
interface memory_target_if;
  logic        available;
  logic        is_write;
  logic        is_unsigned;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] in;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        op_fault;
  logic        addr_fault;
  logic        access_fault;

  modport master (
    output available, is_write, is_unsigned, op, addr, in,
    input  out, busy, done, op_fault, addr_fault, access_fault
  );

  modport slave (
    input  available, is_write, is_unsigned, op, addr, in,
    output out, busy, done, op_fault, addr_fault, access_fault
  );
endinterface

// File: rtl/memory_target.sv
// Word-organised RAM answering byte/half/word requests with sign/zero-extended reads and fault flags.
// Done pulses WAIT_STATES+1 cycles after the request is taken; a held request is served once only.
module memory_target #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic            clk,
  input logic            reset_n,
  memory_target_if.slave bus
);

  localparam int          AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS  = 4'(WAIT_STATES);
  localparam logic [32:0] LIM = 33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        r_write;
  logic        r_unsigned;
  logic [1:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_in;
  logic        busy_q, done_q, op_fault_q, addr_fault_q, access_fault_q;
  logic [31:0] out_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          op_f, addr_f, range_f, any_f;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, rd_data, wr_data;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    be;
  logic          fire;

  // Decode is done on the captured request so the inputs only need to be stable at acceptance.
  assign op_f    = (r_op == 2'b11);
  assign addr_f  = (r_op[1] & (r_addr[1] | r_addr[0])) | (r_op[0] & r_addr[0]);
  assign range_f = ({1'b0, r_addr} < 33'(BASE_ADDR)) || ({1'b0, r_addr} >= LIM);
  assign any_f   = op_f | addr_f | range_f;

  assign idx     = r_addr[AW+1:2] - BASE_ADDR[AW+1:2];
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{r_addr[1:0], 3'b000} +: 8];
  assign rd_half = r_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_data = rd_word;
    wr_data = r_in;
    be      = 4'b1111;
    case (r_op)
      2'b00: begin
        rd_data = r_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        wr_data = {4{r_in[7:0]}};
        be      = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        rd_data = r_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
        wr_data = {2{r_in[15:0]}};
        be      = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // The access edge: request still held, wait count exhausted.
  assign fire = (state == ACCESS) && bus.available && (cnt == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      r_write        <= 1'b0;
      r_unsigned     <= 1'b0;
      r_op           <= 2'b00;
      r_addr         <= 32'h0;
      r_in           <= 32'h0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      out_q          <= 32'h0;
      op_fault_q     <= 1'b0;
      addr_fault_q   <= 1'b0;
      access_fault_q <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      op_fault_q     <= 1'b0;
      addr_fault_q   <= 1'b0;
      access_fault_q <= 1'b0;
      case (state)
        IDLE: if (bus.available) begin
          state      <= ACCESS;
          busy_q     <= 1'b1;
          cnt        <= WS;
          r_write    <= bus.is_write;
          r_unsigned <= bus.is_unsigned;
          r_op       <= bus.op;
          r_addr     <= bus.addr;
          r_in       <= bus.in;
        end
        ACCESS: begin
          if (!bus.available) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state          <= DONE;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            op_fault_q     <= op_f;
            addr_fault_q   <= addr_f;
            access_fault_q <= any_f;
            out_q          <= (any_f || r_write) ? 32'h0 : rd_data;
          end
        end
        DONE: if (!bus.available) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (fire && r_write && !any_f) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.out          = out_q;
  assign bus.op_fault     = op_fault_q;
  assign bus.addr_fault   = addr_fault_q;
  assign bus.access_fault = access_fault_q;

endmodule
